// File: rtl/mlp_pkg.sv
// Shared types and sizing for the single-layer MLP control FSM.
package mlp_pkg;

    localparam int unsigned N_IN    = 256;
    localparam int unsigned N_OUT   = 8;
    localparam int unsigned MAC_LAT = 2;

    localparam int unsigned W_AW  = $clog2(N_IN * N_OUT);
    localparam int unsigned X_AW  = $clog2(N_IN);
    localparam int unsigned ROW_W = $clog2(N_OUT);

    // Terminal counts; one shared counter covers every timed state
    localparam logic [W_AW-1:0]  W_LAST   = W_AW'(N_IN * N_OUT - 1);
    localparam logic [W_AW-1:0]  X_LAST   = W_AW'(N_IN - 1);
    localparam logic [W_AW-1:0]  D_LAST   = W_AW'(MAC_LAT - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(N_OUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoadW,
        StLoadX,
        StMac,
        StDrain,
        StWb,
        StDone
    } state_e;

endpackage

// File: rtl/mlp_fsm.sv
// Control FSM of a single-layer MLP engine: weight/input loads, then a MAC pass
// writing results into the other half of a ping-pong x buffer.
// Optional feature: define MLP_FSM_ACC_CLR_EN to add acc_clr_o (first MAC cycle of each row).
module mlp_fsm
    import mlp_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            init_valid_i,
    output logic            init_ready_o,
    input  logic            start_valid_i,
    output logic            start_ready_o,
    output logic            result_valid_o,
    output logic            w_ren_o,
    output logic            w_wen_o,
    output logic [W_AW-1:0] w_addr_o,
    output logic            x_ren_o,
    output logic            x_wen_o,
    output logic            x_sel_o,
    output logic [X_AW-1:0] x_addr_o
`ifdef MLP_FSM_ACC_CLR_EN
    ,
    output logic            acc_clr_o
`endif
);

    state_e             state_q, state_d;
    logic [W_AW-1:0]    cnt_q, cnt_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic               bank_q, bank_d;
    logic               loaded_q, loaded_d;

    logic               init_ready_d, start_ready_d, result_valid_d;
    logic               w_ren_d, w_wen_d, x_ren_d, x_wen_d, x_sel_d;
    logic [W_AW-1:0]    w_addr_d;
    logic [X_AW-1:0]    x_addr_d;
    logic               acc_clr_d;

    // Next state, counters and flags
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        row_d    = row_q;
        bank_d   = bank_q;
        loaded_d = loaded_q;
        unique case (state_q)
            StIdle: begin
                // init has priority over start when both fire together
                if (init_valid_i) begin
                    state_d = StLoadW;
                    cnt_d   = '0;
                end else if (start_valid_i && loaded_q) begin
                    state_d = StMac;
                    cnt_d   = '0;
                    row_d   = '0;
                end
            end
            StLoadW: begin
                if (cnt_q == W_LAST) begin
                    state_d = StLoadX;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + W_AW'(1);
                end
            end
            StLoadX: begin
                if (cnt_q == X_LAST) begin
                    state_d  = StIdle;
                    cnt_d    = '0;
                    loaded_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + W_AW'(1);
                end
            end
            StMac: begin
                if (cnt_q == X_LAST) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + W_AW'(1);
                end
            end
            StDrain: begin
                if (cnt_q == D_LAST) begin
                    state_d = StWb;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + W_AW'(1);
                end
            end
            StWb: begin
                if (row_q == ROW_LAST) begin
                    state_d = StDone;
                    row_d   = '0;
                end else begin
                    state_d = StMac;
                    row_d   = row_q + ROW_W'(1);
                end
            end
            StDone: begin
                // results just written become the next pass's input
                state_d = StIdle;
                bank_d  = ~bank_q;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                row_d   = '0;
            end
        endcase
    end

    // Moore outputs evaluated on the next state so the registered copies line up with it
    always_comb begin
        init_ready_d   = (state_d == StIdle);
        start_ready_d  = (state_d == StIdle) && loaded_d;
        result_valid_d = (state_d == StDone);
        w_wen_d        = (state_d == StLoadW);
        w_ren_d        = (state_d == StMac);
        x_ren_d        = (state_d == StMac);
        x_wen_d        = (state_d == StLoadX) || (state_d == StWb);
        acc_clr_d      = (state_d == StMac) && (cnt_d == '0);
        w_addr_d       = '0;
        x_addr_d       = '0;
        x_sel_d        = 1'b0;
        if (state_d == StLoadW) begin
            w_addr_d = cnt_d;
        end else if (state_d == StMac) begin
            w_addr_d = {row_d, cnt_d[X_AW-1:0]};
        end
        if ((state_d == StLoadX) || (state_d == StMac)) begin
            x_addr_d = cnt_d[X_AW-1:0];
            x_sel_d  = bank_d;
        end else if (state_d == StWb) begin
            x_addr_d = X_AW'(row_d);
            x_sel_d  = ~bank_d;
        end
    end

    // State, counters, flags and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            row_q          <= '0;
            bank_q         <= 1'b0;
            loaded_q       <= 1'b0;
            init_ready_o   <= 1'b1;
            start_ready_o  <= 1'b0;
            result_valid_o <= 1'b0;
            w_ren_o        <= 1'b0;
            w_wen_o        <= 1'b0;
            w_addr_o       <= '0;
            x_ren_o        <= 1'b0;
            x_wen_o        <= 1'b0;
            x_sel_o        <= 1'b0;
            x_addr_o       <= '0;
`ifdef MLP_FSM_ACC_CLR_EN
            acc_clr_o      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            row_q          <= row_d;
            bank_q         <= bank_d;
            loaded_q       <= loaded_d;
            init_ready_o   <= init_ready_d;
            start_ready_o  <= start_ready_d;
            result_valid_o <= result_valid_d;
            w_ren_o        <= w_ren_d;
            w_wen_o        <= w_wen_d;
            w_addr_o       <= w_addr_d;
            x_ren_o        <= x_ren_d;
            x_wen_o        <= x_wen_d;
            x_sel_o        <= x_sel_d;
            x_addr_o       <= x_addr_d;
`ifdef MLP_FSM_ACC_CLR_EN
            acc_clr_o      <= acc_clr_d;
`endif
        end
    end

`ifndef MLP_FSM_ACC_CLR_EN
    // Without the port the datapath clears on x_wen_o instead
    logic unused_acc_clr;
    assign unused_acc_clr = acc_clr_d;
`endif

endmodule

// File: tb/tb_mlp_fsm.sv
// Directed self-checking bench for mlp_fsm.
module tb_mlp_fsm;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        init_valid_i = 1'b0;
    logic        start_valid_i = 1'b0;
    logic        init_ready_o, start_ready_o, result_valid_o;
    logic        w_ren_o, w_wen_o, x_ren_o, x_wen_o, x_sel_o;
    logic [10:0] w_addr_o;
    logic [7:0]  x_addr_o;
`ifdef MLP_FSM_ACC_CLR_EN
    logic        acc_clr_o;
`endif

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk_i = ~clk_i;

    mlp_fsm dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .init_valid_i   (init_valid_i),
        .init_ready_o   (init_ready_o),
        .start_valid_i  (start_valid_i),
        .start_ready_o  (start_ready_o),
        .result_valid_o (result_valid_o),
        .w_ren_o        (w_ren_o),
        .w_wen_o        (w_wen_o),
        .w_addr_o       (w_addr_o),
        .x_ren_o        (x_ren_o),
        .x_wen_o        (x_wen_o),
        .x_sel_o        (x_sel_o),
        .x_addr_o       (x_addr_o)
`ifdef MLP_FSM_ACC_CLR_EN
        ,
        .acc_clr_o      (acc_clr_o)
`endif
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Nothing enabled, nothing pulsed
    function automatic logic quiet();
        return (w_ren_o === 1'b0) && (w_wen_o === 1'b0) && (x_ren_o === 1'b0) &&
               (x_wen_o === 1'b0) && (result_valid_o === 1'b0);
    endfunction

    task automatic load_all(input logic bank, input string tag);
        int errs = 0;
        init_valid_i = 1'b1;
        tick();
        init_valid_i = 1'b0;
        chk({tag, "_w_first"}, {w_wen_o, w_addr_o}, {1'b1, 11'd0});
        for (int i = 0; i < 2048; i++) begin
            if (!(w_wen_o === 1'b1 && w_addr_o === 11'(i) && x_wen_o === 1'b0 &&
                  w_ren_o === 1'b0 && x_ren_o === 1'b0)) errs++;
            if (i == 2047) chk({tag, "_w_last"}, {w_wen_o, w_addr_o}, {1'b1, 11'd2047});
            tick();
        end
        chk({tag, "_w_seq_errs"}, errs, 0);
        errs = 0;
        for (int j = 0; j < 256; j++) begin
            if (!(x_wen_o === 1'b1 && x_sel_o === bank && x_addr_o === 8'(j) &&
                  w_wen_o === 1'b0 && start_ready_o === 1'b0)) errs++;
            if (j == 255) chk({tag, "_x_last"}, {x_wen_o, x_sel_o, x_addr_o},
                              {1'b1, bank, 8'd255});
            tick();
        end
        chk({tag, "_x_seq_errs"}, errs, 0);
        chk({tag, "_idle_quiet"}, quiet(), 1'b1);
        chk({tag, "_start_ready"}, {init_ready_o, start_ready_o}, 2'b11);
    endtask

    // Full pass; result_valid_o must appear exactly 2073 cycles after start fires
    task automatic run_pass(input logic bank, input string tag);
        int errs = 0;
        start_valid_i = 1'b1;
        tick();
        start_valid_i = 1'b0;
        for (int o = 0; o < 8; o++) begin
            for (int i = 0; i < 256; i++) begin
                if (!(w_ren_o === 1'b1 && x_ren_o === 1'b1 && w_addr_o === 11'(o * 256 + i) &&
                      x_addr_o === 8'(i) && x_sel_o === bank && w_wen_o === 1'b0 &&
                      x_wen_o === 1'b0 && result_valid_o === 1'b0)) errs++;
                if (o == 1 && i == 0) chk({tag, "_row1_w_addr"}, w_addr_o, 11'd256);
                if (o == 1 && i == 255) chk({tag, "_row1_w_end"}, w_addr_o, 11'd511);
                tick();
            end
            for (int d = 0; d < 2; d++) begin
                if (!quiet()) errs++;
                tick();
            end
            if (!(x_wen_o === 1'b1 && x_sel_o === ~bank && x_addr_o === 8'(o) &&
                  w_ren_o === 1'b0 && x_ren_o === 1'b0 && result_valid_o === 1'b0)) errs++;
            if (o == 1) chk({tag, "_wb_row1"}, {x_wen_o, x_sel_o, x_addr_o}, {1'b1, ~bank, 8'd1});
            tick();
        end
        chk({tag, "_seq_errs"}, errs, 0);
        chk({tag, "_result_valid"}, {result_valid_o, w_ren_o, x_wen_o}, 3'b100);
        tick();
        chk({tag, "_result_pulse_end"}, result_valid_o, 1'b0);
        chk({tag, "_back_idle"}, {init_ready_o, start_ready_o}, 2'b11);
    endtask

    initial begin
        // Reset held for 10 cycles
        rst_ni = 1'b0;
        repeat (10) tick();
        chk("rst_quiet", quiet(), 1'b1);
        chk("rst_addr", {w_addr_o, x_addr_o, x_sel_o}, '0);
        chk("rst_ready", {init_ready_o, start_ready_o}, 2'b10);
        rst_ni = 1'b1;
        tick();

        // start before any init is not accepted
        start_valid_i = 1'b1;
        tick();
        start_valid_i = 1'b0;
        chk("early_start_quiet", quiet(), 1'b1);
        repeat (3) tick();
        chk("early_start_idle", {init_ready_o, start_ready_o, w_ren_o, x_ren_o}, 4'b1000);

        load_all(1'b0, "load0");
        repeat (2) tick();
        run_pass(1'b0, "pass0");
        run_pass(1'b1, "pass1");

        // Abort mid-MAC on bank 0
        start_valid_i = 1'b1;
        tick();
        start_valid_i = 1'b0;
        repeat (100) tick();
        chk("abort_pre_mac", {w_ren_o, w_addr_o, x_sel_o}, {1'b1, 11'd100, 1'b0});
        rst_ni = 1'b0;
        #1;
        chk("abort_async_quiet", quiet(), 1'b1);
        chk("abort_async_ready", {init_ready_o, start_ready_o}, 2'b10);
        tick();
        rst_ni = 1'b1;
        tick();
        start_valid_i = 1'b1;
        tick();
        start_valid_i = 1'b0;
        chk("abort_loaded_cleared", {quiet(), start_ready_o}, 2'b10);

        // Reload then present init and start together: init wins
        load_all(1'b0, "load1");
        init_valid_i  = 1'b1;
        start_valid_i = 1'b1;
        tick();
        init_valid_i  = 1'b0;
        start_valid_i = 1'b0;
        chk("both_valid_load_w", {w_wen_o, w_ren_o, x_ren_o, w_addr_o}, {3'b100, 11'd0});
        tick();
        chk("both_valid_load_w2", {w_wen_o, w_ren_o, w_addr_o}, {2'b10, 11'd1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
